// File: rtl/mcp3_ram_pkg.sv
// mcp3_ram_pkg: shared types, collision modes and byte-merge helper for the MCP3 SDP RAM
package mcp3_ram_pkg;
    typedef enum logic {ST_INIT, ST_READY} state_t;
    localparam bit COLL_OLD = 1'b0;
    localparam bit COLL_NEW = 1'b1;
    function automatic logic [7:0] be_merge(input logic [7:0] old_b, input logic [7:0] new_b, input logic en);
        return en ? new_b : old_b;
    endfunction
endpackage

// File: rtl/mcp3_ram_sdp_bq_if.sv
// mcp3_ram_sdp_bq_if: write/read port bundle of the MCP3 simple-dual-port RAM
interface mcp3_ram_sdp_bq_if #(parameter int WIDTH = 64, parameter int ADDR_W = 9);
    logic              wren;
    logic [ADDR_W-1:0] wrad;
    logic [WIDTH/8-1:0] wrbe;
    logic [WIDTH-1:0]  data;
    logic              rden;
    logic [ADDR_W-1:0] rdad;
    logic [WIDTH-1:0]  q;
    logic              q_valid;
    logic              init_done;
    modport master (output wren, wrad, wrbe, data, rden, rdad, input q, q_valid, init_done);
    modport slave (input wren, wrad, wrbe, data, rden, rdad, output q, q_valid, init_done);
endinterface

// File: rtl/mcp3_ram_sdp_core.sv
// mcp3_ram_sdp_core: bare read-first block RAM array with byte writes, no reset
module mcp3_ram_sdp_core #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 9
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  wa,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   wd,
    input  logic [ADDR_W-1:0]  ra,
    output logic [WIDTH-1:0]   rd
);
    (* ram_style = "block" *) logic [WIDTH-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH / 8; i++)
            if (we && be[i]) mem[wa][8*i+:8] <= wd[8*i+:8];
        rd <= mem[ra];
    end
endmodule

// File: rtl/mcp3_ram_sdp_bq.sv
// mcp3_ram_sdp_bq: SDP RAM with byte enables, 1/2-cycle read latency, collision bypass
// and an optional zero-fill sweep after reset.
module mcp3_ram_sdp_bq import mcp3_ram_pkg::*; #(
    parameter int WIDTH         = 64,
    parameter int ADDR_W        = 9,
    parameter bit OUT_REG       = 1'b1,
    parameter bit BYPASS        = COLL_NEW,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input logic clk,
    input logic reset_n,
    mcp3_ram_sdp_bq_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = WIDTH / 8;
    if (WIDTH % 8 != 0) begin : g_width_check
        $error("mcp3_ram_sdp_bq: WIDTH must be a multiple of 8");
    end
    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic                init_done_r;
    logic                sweep, acc_wr, acc_rd;
    logic                v1, v2;
    logic [NB-1:0]       byp_be;
    logic [WIDTH-1:0]    byp_d, core_q, stage1, q_r;
    assign sweep  = reset_n && state == ST_INIT;
    assign acc_wr = reset_n && init_done_r && bus.wren;
    assign acc_rd = reset_n && init_done_r && bus.rden;
    mcp3_ram_sdp_core #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_core (
        .clk (clk),
        .we  (sweep || acc_wr),
        .wa  (sweep ? cnt : bus.wrad),
        .be  (sweep ? {NB{1'b1}} : bus.wrbe),
        .wd  (sweep ? '0 : bus.data),
        .ra  (bus.rdad),
        .rd  (core_q)
    );
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= INIT_ON_RESET ? ST_INIT : ST_READY;
            cnt         <= '0;
            init_done_r <= 1'b0;
        end else begin
            init_done_r <= state == ST_READY;
            if (state == ST_INIT) begin
                cnt <= cnt + 1'b1;
                if (cnt == ADDR_W'(DEPTH - 1)) state <= ST_READY;
            end
        end
    end
    // Core reads old data; bytes written by a colliding write are patched in afterwards
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            byp_be <= '0;
            byp_d  <= '0;
            q_r    <= '0;
        end else begin
            v1     <= acc_rd;
            v2     <= v1;
            byp_be <= (BYPASS != COLL_OLD && acc_rd && acc_wr && bus.wrad == bus.rdad) ? bus.wrbe : '0;
            byp_d  <= bus.data;
            q_r    <= stage1;
        end
    end
    always_comb begin
        stage1 = '0;
        for (int i = 0; i < NB; i++)
            stage1[8*i+:8] = v1 ? be_merge(core_q[8*i+:8], byp_d[8*i+:8], byp_be[i]) : 8'h00;
    end
    assign bus.q         = OUT_REG ? q_r : stage1;
    assign bus.q_valid   = OUT_REG ? v2 : v1;
    assign bus.init_done = init_done_r;
endmodule

// File: tb/tb_mcp3_ram_sdp_bq.sv
// tb_mcp3_ram_sdp_bq: directed + random checks of mcp3_ram_sdp_bq against an array model
module tb_mcp3_ram_sdp_bq;
    localparam int W       = 64;
    localparam int AW      = 9;
    localparam int DEPTH   = 2 ** AW;
    localparam bit OUT_REG = 1'b1;
    localparam bit BYPASS  = 1'b1;
    localparam int LAT     = OUT_REG ? 2 : 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_pass = 0;
    int n_total = 0;
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] hist_q[$];
    logic hist_v[$];

    always #5 clk = ~clk;

    mcp3_ram_sdp_bq_if #(.WIDTH(W), .ADDR_W(AW)) bus ();
    mcp3_ram_sdp_bq #(.WIDTH(W), .ADDR_W(AW), .OUT_REG(OUT_REG), .BYPASS(BYPASS), .INIT_ON_RESET(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, want);
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [7:0] be,
                         input logic [W-1:0] d, input logic re, input logic [AW-1:0] ra);
        bus.wren = we; bus.wrad = wa; bus.wrbe = be; bus.data = d;
        bus.rden = re; bus.rdad = ra;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
        hist_q = {};
        hist_v = {};
        for (int i = 0; i < LAT; i++) begin
            hist_q.push_back('0);
            hist_v.push_back(1'b0);
        end
    endtask

    // One ready-state cycle: drive, predict, clock, compare outputs against the latency queue
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [7:0] be,
                       input logic [W-1:0] d, input logic re, input logic [AW-1:0] ra);
        logic [W-1:0] rv;
        drive(we, wa, be, d, re, ra);
        rv = '0;
        if (re) begin
            rv = mem[ra];
            if (BYPASS && we && wa == ra)
                for (int b = 0; b < 8; b++) if (be[b]) rv[8*b+:8] = d[8*b+:8];
        end
        if (we)
            for (int b = 0; b < 8; b++) if (be[b]) mem[wa][8*b+:8] = d[8*b+:8];
        hist_q.push_back(rv);
        hist_v.push_back(re);
        if (hist_q.size() > LAT) begin
            void'(hist_q.pop_front());
            void'(hist_v.pop_front());
        end
        tick();
        chk("model_q", bus.q, hist_q[0]);
        chk("model_q_valid", W'(bus.q_valid), W'(hist_v[0]));
    endtask

    task automatic read_expect(input string tag, input logic [AW-1:0] ra, input logic [W-1:0] want);
        cyc(1'b0, '0, '0, '0, 1'b1, ra);
        for (int i = 1; i < LAT; i++) cyc(1'b0, '0, '0, '0, 1'b0, '0);
        chk(tag, bus.q, want);
        chk({tag, "_valid"}, W'(bus.q_valid), W'(1));
    endtask

    // Sweep with port activity that must be ignored; init_done rises on cycle DEPTH+1
    task automatic do_init(input string tag);
        int bad;
        bad = 0;
        for (int k = 1; k <= DEPTH; k++) begin
            drive(1'b1, AW'(7), 8'hFF, '1, 1'b1, AW'($urandom_range(0, DEPTH - 1)));
            tick();
            if (bus.init_done !== 1'b0 || bus.q_valid !== 1'b0 || bus.q !== '0) bad++;
        end
        chk({tag, "_quiet"}, W'(bad), W'(0));
        idle();
        tick();
        chk({tag, "_done"}, W'(bus.init_done), W'(1));
        model_reset();
    endtask

    initial begin
        int bad;
        idle();
        repeat (3) tick();
        chk("rst_q", bus.q, '0);
        chk("rst_q_valid", W'(bus.q_valid), W'(0));
        chk("rst_init_done", W'(bus.init_done), W'(0));
        reset_n = 1'b1;
        do_init("init1");

        read_expect("zero_0", AW'(0), '0);
        read_expect("zero_255", AW'(255), '0);
        read_expect("zero_511", AW'(511), '0);

        cyc(1'b1, AW'(5), 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0, '0);
        read_expect("full_wr", AW'(5), 64'hDEADBEEF_CAFEF00D);
        cyc(1'b1, AW'(5), 8'h0F, 64'h11111111_11111111, 1'b0, '0);
        read_expect("part_wr", AW'(5), 64'hDEADBEEF_11111111);
        cyc(1'b1, AW'(5), 8'h00, 64'h22222222_22222222, 1'b0, '0);
        read_expect("be_zero", AW'(5), 64'hDEADBEEF_11111111);

        cyc(1'b1, AW'(5), 8'hF0, 64'hAAAAAAAA_AAAAAAAA, 1'b1, AW'(5));
        for (int i = 1; i < LAT; i++) cyc(1'b0, '0, '0, '0, 1'b0, '0);
        chk("collide", bus.q, BYPASS ? 64'hAAAAAAAA_11111111 : 64'hDEADBEEF_11111111);
        read_expect("after_coll", AW'(5), 64'hAAAAAAAA_11111111);

        for (int a = 0; a < 4; a++) cyc(1'b1, AW'(a), 8'hFF, W'(a + 1), 1'b0, '0);
        for (int j = 0; j < 4 + LAT; j++) begin
            cyc(1'b0, '0, '0, '0, j < 4, AW'(j < 4 ? j : 0));
            if (j >= LAT - 1 && j - LAT + 1 < 4) chk("b2b", bus.q, W'(j - LAT + 2));
        end
        chk("b2b_idle_q", bus.q, '0);
        chk("b2b_idle_valid", W'(bus.q_valid), W'(0));

        for (int n = 0; n < 400; n++)
            cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 8'($urandom),
                {$urandom, $urandom}, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));

        cyc(1'b1, AW'(7), 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, '0);
        read_expect("pre_rst_7", AW'(7), 64'h0123_4567_89AB_CDEF);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, AW'(7), 8'hFF, '1, 1'b1, AW'(7));
            tick();
            if (bus.init_done !== 1'b0 || bus.q_valid !== 1'b0 || bus.q !== '0) bad++;
        end
        chk("sweep100_quiet", W'(bad), W'(0));
        reset_n = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.init_done !== 1'b0 || bus.q_valid !== 1'b0 || bus.q !== '0) bad++;
        end
        chk("midrst_quiet", W'(bad), W'(0));
        reset_n = 1'b1;
        do_init("init2");
        read_expect("addr7_zero", AW'(7), '0);
        read_expect("addr5_zero", AW'(5), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
